// File: rtl/reg_arb_pkg.sv
// Shared constants and helpers for the round-robin write arbiter.
// Build option ARB_LOCK_EN (see reg_bank_write_arbiter.sv) adds the lock input.
package reg_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int MAX_REQ     = 8;

  // Index width that never collapses to zero bits for small n.
  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx[2:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               any,
  output logic [NUM_REQ-1:0] grant
);

  logic [MAX_REQ-1:0] oh;

  always_comb begin
    int idx;
    winner = '0;
    // Scan from farthest to nearest so the nearest requester is assigned last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) winner = IW'(idx);
    end
  end

  always_comb begin
    any = |req;
    oh  = onehot(int'(winner));
    grant = any ? oh[NUM_REQ-1:0] : '0;
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Shared q/qbar register written by NUM_REQ round-robin requesters, with write counter.
// Define ARB_LOCK_EN to add the lock input that lets a winner keep priority for bursts.
module reg_bank_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         q,
  output logic [DATA_W-1:0]         qbar,
  output logic                      wr_valid,
  output logic [IW-1:0]             wr_src,
  output logic [CNT_W-1:0]          wr_count
);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      winner;
  logic               any;
  logic [NUM_REQ-1:0] pick_grant;
  logic [DATA_W-1:0]  win_data;
  logic [IW-1:0]      ptr_next;
  logic               hold_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any),
    .grant  (pick_grant)
  );

  always_comb begin
    grant    = reset ? '0 : pick_grant;
    win_data = wdata[winner*DATA_W +: DATA_W];
`ifdef ARB_LOCK_EN
    hold_ptr = lock[winner];
`else
    hold_ptr = 1'b0;
`endif
    if (hold_ptr)
      ptr_next = winner;
    else if (winner == IW'(NUM_REQ - 1))
      ptr_next = '0;
    else
      ptr_next = winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      q        <= '0;
      qbar     <= '1;
      wr_valid <= 1'b0;
      wr_src   <= '0;
      wr_count <= '0;
    end else if (any) begin
      ptr      <= ptr_next;
      q        <= win_data;
      qbar     <= ~win_data;
      wr_valid <= 1'b1;
      wr_src   <= winner;
      if (wr_count != '1) wr_count <= wr_count + 1'b1;
    end else begin
      wr_valid <= 1'b0;
    end
  end

endmodule
